crypto1_key_collector: RTL
==========================

// Module: crypto1_key_collector
// PURPOSE
//  Reader side of the per-core serial key interface (KEY_VALID/KEY_CLK/KEY_DATA) of the Crypto1 search array.
//  Watches NCORES search cores and picks the lowest-index core that finished with a key.
//  Clocks that core's 48-bit key out serially, MSB first, and presents it on a ready/ack handshake.
//  Reports exhaustion when every core is done and no unconsumed key remains. Sits between the core array and host/UART.
// PARAMETERS
//  NCORES   256   number of attached search cores (one per even/odd index pair); >=1
//  IDXW     $clog2(NCORES) (min 1)   width of the core index
// PORTS
//  CLK             in   1       system clock
//  RESETn          in   1       reset, asynchronous assert, active-low
//  CORE_DONE       in   NCORES  per-core DONE
//  CORE_KEY_VALID  in   NCORES  per-core KEY_VALID
//  CORE_KEY_DATA   in   NCORES  per-core serial key bit (registered in core)
//  CORE_KEY_CLK    out  NCORES  per-core shift strobe, one-hot, 1-cycle pulses
//  KEY             out  48      assembled key, KEY[47] = first bit received
//  KEY_IDX         out  IDXW    index of core that produced KEY
//  KEY_READY       out  1       KEY/KEY_IDX valid; held until KEY_ACK
//  KEY_ACK         in   1       consumer accepts key
//  SEARCH_DONE     out  1       all cores done, no pending/unconsumed key; sticky
// BEHAVIOUR
//  Interface: one clock, reset asynchronous active-low. All inputs are CLK-synchronous; there are no synchronizers.
//  Reset values: CORE_KEY_CLK=0, KEY=0, KEY_IDX=0, KEY_READY=0, SEARCH_DONE=0, consumed mask=0, state=SCAN.
//  Candidate = CORE_DONE & CORE_KEY_VALID & ~consumed. Selection is by a lowest-index priority encoder.
//  States:
//   SCAN
//    - candidate exists: latch idx, clear bit counter -> PULSE.
//    - else if &CORE_DONE: -> EXHAUSTED.
//   PULSE
//    - CORE_KEY_CLK[idx]=1 during this cycle only; all other bits 0.
//    - -> SAMPLE.
//   SAMPLE
//    - shift = {shift[46:0], CORE_KEY_DATA[idx]}; cnt++.
//    - cnt reaches 48 -> PRESENT; else -> PULSE.
//   PRESENT
//    - KEY<=shift, KEY_IDX<=idx, KEY_READY=1.
//    - On KEY_ACK: set consumed[idx], drop KEY_READY next cycle -> SCAN.
//   EXHAUSTED
//    - SEARCH_DONE=1 until reset.
//  CORE_KEY_CLK is driven from a register: the pulse is high in the PULSE cycle.
//  The core updates KEY_DATA on that edge, so the bit is sampled in the following SAMPLE cycle.
//  Timing: 2 cycles/bit, 96 shift cycles. KEY_READY rises 97 cycles after the SCAN cycle that selected the core.
//  Boundaries:
//   - KEY_ACK outside PRESENT: ignored.
//   - KEY_ACK same cycle KEY_READY rises: accepted.
//   - KEY_READY with ACK low: KEY/KEY_IDX stable indefinitely.
//   - Multiple candidates: lowest index first; others are served after ACK (false positives are reported individually).
//   - Core KEY_VALID rising during another core's shift: not preempted, picked up at next SCAN.
//   - Selected core losing DONE/KEY_VALID mid-shift: shift completes anyway; key reported as captured.
//   - A core's key is destroyed by shifting, so each core is read at most once (consumed mask).
//   - All done with keys pending: keys served first, SEARCH_DONE only after last ACK.
//   - RESETn low mid-shift: immediate return to reset values. The cores are reset by the same RESETn.
// STRUCTURE
//  crypto1_pkg: KEY_WIDTH=48, collector_state_t enum {SCAN,PULSE,SAMPLE,PRESENT,EXHAUSTED}.
//  Sub-module crypto1_key_deser: shift register + 6-bit bit counter + strobe generation for one selected lane.
//  Priority encoder, consumed mask and FSM stay in the top level.
// TESTING
//  1. Reset: all outputs at reset values. NCORES=4, no DONE -> stays SCAN, CORE_KEY_CLK=0, SEARCH_DONE=0.
//  2. Core 2 DONE+VALID, key 48'hA5A5_0123_CDEF -> 48 pulses only on CORE_KEY_CLK[2].
//     KEY=48'hA5A5_0123_CDEF, KEY_IDX=2, KEY_READY at cycle 97.
//  3. Cores 1 and 3 valid simultaneously (keys 48'h1, 48'hFFFF_FFFF_FFFF) -> core 1 first; hold ACK low 20 cycles, KEY stable.
//     After ACK, core 3 is read; after its ACK, SEARCH_DONE=1.
//  4. All cores DONE with KEY_VALID=0 -> SEARCH_DONE=1 within 2 cycles, zero CORE_KEY_CLK pulses.
//  5. RESETn low at bit 20 of a shift -> outputs at reset values asynchronously (same cycle).
//     After release with fresh key 48'h0000_0000_0001 -> full correct read.
//  6. Core 0 raises VALID while core 3 is mid-shift -> core 3 key completes intact; core 0 read after ACK.

Source files
------------

// File: rtl/crypto1_pkg.sv
// Shared types and constants for the Crypto1 key collection path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package crypto1_pkg;
    localparam int KEY_WIDTH = 48;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        SCAN,
        PULSE,
        SAMPLE,
        PRESENT,
        EXHAUSTED
    } collector_state_t;
endpackage

// File: rtl/crypto1_key_deser.sv
// Serial key deserializer for one selected core lane, with registered one-hot shift strobe.
// Latency: strobe is registered (high the cycle after strobe_nxt); each sample adds one bit.
// Backpressure: none; the collector FSM paces pulses and samples.
module crypto1_key_deser
    import crypto1_pkg::*;
#(
    parameter int NCORES = 256,
    parameter int IDXW   = 8
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 strobe_nxt,
    input  logic [IDXW-1:0]      lane_nxt,
    input  logic [IDXW-1:0]      lane,
    input  logic                 clear,
    input  logic                 sample,
    input  logic [NCORES-1:0]    key_data,
    output logic [NCORES-1:0]    key_clk,
    output logic [KEY_WIDTH-1:0] word,
    output logic                 last
);
    logic [KEY_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NCORES-1:0]    onehot;
    logic                 bit_in;

    always_comb begin
        onehot           = '0;
        onehot[lane_nxt] = 1'b1;
        bit_in           = key_data[lane];
        // word includes the bit sampled this cycle so the top can latch the full key on the last sample
        word             = {shift_q[KEY_WIDTH-2:0], bit_in};
        last             = sample && (cnt_q == CNT_W'(KEY_WIDTH - 1));
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            shift_q <= '0;
            cnt_q   <= '0;
            key_clk <= '0;
        end else begin
            key_clk <= strobe_nxt ? onehot : '0;
            if (clear) begin
                cnt_q <= '0;
            end else if (sample) begin
                shift_q <= word;
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/crypto1_key_collector.sv
// Picks the lowest-index finished core with a key, reads its key serially and presents it to the host.
// Latency: KEY_READY rises 97 cycles after the selecting SCAN cycle (2 cycles per bit plus present).
// Backpressure: KEY/KEY_IDX/KEY_READY held until KEY_ACK; no further core is read meanwhile.
module crypto1_key_collector
    import crypto1_pkg::*;
#(
    parameter int NCORES = 256,
    parameter int IDXW   = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [NCORES-1:0]    CORE_DONE,
    input  logic [NCORES-1:0]    CORE_KEY_VALID,
    input  logic [NCORES-1:0]    CORE_KEY_DATA,
    output logic [NCORES-1:0]    CORE_KEY_CLK,
    output logic [KEY_WIDTH-1:0] KEY,
    output logic [IDXW-1:0]      KEY_IDX,
    output logic                 KEY_READY,
    input  logic                 KEY_ACK,
    output logic                 SEARCH_DONE
);
    collector_state_t state_q, state_nxt;
    logic [IDXW-1:0]      idx_q, sel, lane_nxt;
    logic [NCORES-1:0]    consumed_q, cand;
    logic                 found, load_idx, accept, last;
    logic [KEY_WIDTH-1:0] word;

    // lowest index wins: scan downward so the last hit is the smallest index
    always_comb begin
        cand  = CORE_DONE & CORE_KEY_VALID & ~consumed_q;
        found = 1'b0;
        sel   = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                sel   = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        load_idx  = 1'b0;
        accept    = 1'b0;
        case (state_q)
            SCAN: begin
                if (found) begin
                    load_idx  = 1'b1;
                    state_nxt = PULSE;
                end else if (&CORE_DONE) begin
                    state_nxt = EXHAUSTED;
                end
            end
            PULSE:     state_nxt = SAMPLE;
            SAMPLE:    state_nxt = last ? PRESENT : PULSE;
            PRESENT: begin
                if (KEY_ACK) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            EXHAUSTED: state_nxt = EXHAUSTED;
            default:   state_nxt = SCAN;
        endcase
        lane_nxt = load_idx ? sel : idx_q;
    end

    crypto1_key_deser #(
        .NCORES (NCORES),
        .IDXW   (IDXW)
    ) u_deser (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .strobe_nxt (state_nxt == PULSE),
        .lane_nxt   (lane_nxt),
        .lane       (idx_q),
        .clear      (load_idx),
        .sample     (state_q == SAMPLE),
        .key_data   (CORE_KEY_DATA),
        .key_clk    (CORE_KEY_CLK),
        .word       (word),
        .last       (last)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= SCAN;
            idx_q       <= '0;
            consumed_q  <= '0;
            KEY         <= '0;
            KEY_IDX     <= '0;
            KEY_READY   <= 1'b0;
            SEARCH_DONE <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (load_idx) begin
                idx_q <= sel;
            end
            if (last) begin
                KEY       <= word;
                KEY_IDX   <= idx_q;
                KEY_READY <= 1'b1;
            end
            // a shifted-out key is gone from the core, so never select it again
            if (accept) begin
                consumed_q[idx_q] <= 1'b1;
                KEY_READY         <= 1'b0;
            end
            if (state_nxt == EXHAUSTED) begin
                SEARCH_DONE <= 1'b1;
            end
        end
    end
endmodule
